// File: rtl/rss_issue_ctl_if.sv
// Issue-control bundle between the reservation-station buffer, the FUs and rss_issue_ctl.
// Bit N of every vector belongs to port/FU N.
interface rss_issue_ctl_if;
    logic       stall;
    logic [3:0] portReady;
    logic [3:0] outThread;
    logic [3:0] fuRet;
    logic       flush;
    logic       flushThread;
    logic [3:0] outRsSelect;
    logic [3:0] issueValid;
    logic [3:0] issueThread;
    logic       creditErr;

    modport master (
        output stall, portReady, outThread, fuRet, flush, flushThread,
        input  outRsSelect, issueValid, issueThread, creditErr
    );

    modport slave (
        input  stall, portReady, outThread, fuRet, flush, flushThread,
        output outRsSelect, issueValid, issueThread, creditErr
    );
endinterface

// File: rtl/rss_issue_ctl.sv
// Credit-based select and one-cycle issue stage for four rss_buf ports,
// limited to three selects per cycle with a rotating drop pointer.
module rss_issue_ctl #(
    parameter int CREDITS = 4
) (
    input logic            clk,
    input logic            rst,
    rss_issue_ctl_if.slave bus
);
    localparam logic [3:0] CMAX = 4'(CREDITS);

    logic [2:0] credit [4];
    logic [3:0] sum    [4];
    logic [1:0] ptr;
    logic [3:0] cand;
    logic [3:0] kill;
    logic [3:0] sel;
    logic [3:0] over;
    logic       all4;
    logic [3:0] iss_valid;
    logic [3:0] iss_thread;
    logic       err;

    always_comb begin
        cand = '0;
        kill = '0;
        for (int n = 0; n < 4; n++) begin
            cand[n] = bus.portReady[n] & (credit[n] != 3'd0) & ~bus.stall
                    & ~(bus.flush & (bus.outThread[n] == bus.flushThread));
            kill[n] = bus.flush & iss_valid[n]
                    & (iss_thread[n] == bus.flushThread);
        end
    end

    // Only three issue write ports: with four candidates one is dropped in turn.
    assign all4 = &cand;

    always_comb begin
        sel = cand;
        if (all4) begin
            sel[ptr] = 1'b0;
        end
        if (rst) begin
            sel = '0;
        end
    end

    always_comb begin
        over = '0;
        for (int n = 0; n < 4; n++) begin
            sum[n] = {1'b0, credit[n]} + {3'b0, bus.fuRet[n]}
                   + {3'b0, kill[n]} - {3'b0, sel[n]};
            over[n] = (sum[n] > CMAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                credit[n] <= CMAX[2:0];
            end
            ptr        <= 2'd0;
            iss_valid  <= '0;
            iss_thread <= '0;
            err        <= 1'b0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                credit[n] <= over[n] ? CMAX[2:0] : sum[n][2:0];
            end
            if (all4) begin
                ptr <= ptr + 2'd1;
            end
            // A stalled stage keeps its ops, but a flush can still kill them.
            if (bus.stall) begin
                iss_valid <= iss_valid & ~kill;
            end else begin
                iss_valid  <= sel;
                iss_thread <= bus.outThread;
            end
            err <= err | (|over);
        end
    end

    assign bus.outRsSelect = sel;
    assign bus.issueValid  = iss_valid;
    assign bus.issueThread = iss_thread;
    assign bus.creditErr   = err;
endmodule
